// File: rtl/if_pkg.sv
// if_pkg: shared constants, FSM states and redirect source encoding for the IF fetch controller.
package if_pkg;
    localparam int ADDR_W = 30;
    localparam logic [29:0] START_ADDR = 30'h0000C00;
    localparam logic [29:0] EXC_VECTOR = 30'h0001060;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;
    // Encoded so that a larger value means a higher-priority redirect.
    typedef enum logic [1:0] {NONE = 2'd0, BR = 2'd1, ERET = 2'd2, EXC = 2'd3} src_t;
endpackage

// File: rtl/redir_sel.sv
// redir_sel: priority mux picking exception > ERET > branch as the redirect source and target.
module redir_sel #(
    parameter int ADDR_W = 30,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = if_pkg::EXC_VECTOR
) (
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] epc,
    input  logic [ADDR_W-1:0] br_target,
    output logic              redir,
    output logic [1:0]        redir_src,
    output logic [ADDR_W-1:0] redir_target
);
    import if_pkg::*;
    assign redir = exc_req | eret_req | br_taken;
    assign redir_src = exc_req ? EXC : eret_req ? ERET : br_taken ? BR : NONE;
    assign redir_target = exc_req ? EXC_VECTOR : eret_req ? epc : br_target;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage PC sequencer, imem request/ack handshake and redirect arbitration.
module if_fetch_ctrl #(
    parameter int ADDR_W = 30,
    parameter logic [ADDR_W-1:0] START_ADDR = if_pkg::START_ADDR,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = if_pkg::EXC_VECTOR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              pc_write,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc
);
    import if_pkg::*;

    state_t            state, state_nx;
    logic [1:0]        pend_src, pend_src_nx, redir_src;
    logic [ADDR_W-1:0] pend_tgt, pend_tgt_nx, redir_target, hold_pc, eff_tgt;
    logic [31:0]       hold_instr;
    logic              redir, hold_load, take_new;
    logic [1:0]        eff_src;

    redir_sel #(.ADDR_W(ADDR_W), .EXC_VECTOR(EXC_VECTOR)) u_redir_sel (
        .exc_req(exc_req),
        .eret_req(eret_req),
        .br_taken(br_taken),
        .epc(epc),
        .br_target(br_target),
        .redir(redir),
        .redir_src(redir_src),
        .redir_target(redir_target)
    );

    assign imem_addr = pc;
    // A redirect arriving during DRAIN only displaces a pending one of lower or equal priority.
    assign take_new = redir && (redir_src >= pend_src);
    assign eff_src = take_new ? redir_src : pend_src;
    assign eff_tgt = take_new ? redir_target : pend_tgt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pend_src   <= NONE;
            pend_tgt   <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            state    <= state_nx;
            pend_src <= pend_src_nx;
            pend_tgt <= pend_tgt_nx;
            if (hold_load) begin
                hold_instr <= imem_rdata;
                hold_pc    <= pc;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        pend_src_nx = pend_src;
        pend_tgt_nx = pend_tgt;
        hold_load   = 1'b0;
        npc         = pc;
        pc_write    = 1'b0;
        imem_req    = 1'b0;
        if_valid    = 1'b0;
        if_instr    = '0;
        if_pc       = '0;
        if (!reset) begin
            npc = START_ADDR;
        end else begin
            case (state)
                IDLE: state_nx = REQ;
                REQ: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        pc_write = 1'b1;
                        npc      = redir ? redir_target : pc + 1'b1;
                        if (!redir) begin
                            if_valid  = 1'b1;
                            if_instr  = imem_rdata;
                            if_pc     = pc;
                            hold_load = stall;
                            state_nx  = stall ? HOLD : REQ;
                        end
                    end else if (redir) begin
                        // The outstanding request cannot be aborted; wait for its ack.
                        pend_src_nx = redir_src;
                        pend_tgt_nx = redir_target;
                        state_nx    = DRAIN;
                    end
                end
                DRAIN: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        pc_write    = 1'b1;
                        npc         = eff_tgt;
                        pend_src_nx = NONE;
                        pend_tgt_nx = '0;
                        state_nx    = REQ;
                    end else begin
                        pend_src_nx = eff_src;
                        pend_tgt_nx = eff_tgt;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        pc_write = 1'b1;
                        npc      = redir_target;
                        state_nx = REQ;
                    end else begin
                        if_valid = 1'b1;
                        if_instr = hold_instr;
                        if_pc    = hold_pc;
                        state_nx = stall ? HOLD : REQ;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scenarios for the IF fetch controller with a behavioural PC register.
module tb_if_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] pc, npc, imem_addr, br_target, epc, if_pc;
    logic        pc_write, imem_req, imem_ack, stall, br_taken, exc_req, eret_req, if_valid;
    logic [31:0] imem_rdata, if_instr;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    // Memory returns a word tagged with its own address so if_instr is traceable.
    assign imem_rdata = {2'b10, imem_addr};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= 30'h0000C00;
        else if (pc_write) pc <= npc;
    end

    if_fetch_ctrl dut (
        .clk(clk), .reset(reset), .pc(pc), .npc(npc), .pc_write(pc_write),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req),
        .epc(epc), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
    );

    task automatic set_in(input logic a, input logic s, input logic b, input logic [29:0] bt,
                          input logic e, input logic r, input logic [29:0] ep);
        imem_ack = a; stall = s; br_taken = b; br_target = bt; exc_req = e; eret_req = r; epc = ep;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [29:0] e;
        set_in(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0);
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b000) $display("FAIL reset_ctl got=%b exp=000", {pc_write, imem_req, if_valid}); else passed++;
        total++; if (npc !== 30'h0000C00) $display("FAIL reset_npc got=%h exp=0000c00", npc); else passed++;
        total++; if ({if_instr, if_pc} !== 62'h0) $display("FAIL reset_ifid got=%h/%h exp=0/0", if_instr, if_pc); else passed++;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b000) $display("FAIL idle_ctl got=%b exp=000", {pc_write, imem_req, if_valid}); else passed++;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            e = 30'h0000C00 + 30'(i);
            @(negedge clk);
            total++; if ({pc_write, imem_req, if_valid} !== 3'b111) $display("FAIL seq_ctl%0d got=%b exp=111", i, {pc_write, imem_req, if_valid}); else passed++;
            total++; if (if_pc !== e || if_instr !== {2'b10, e}) $display("FAIL seq_pc%0d got=%h/%h exp=%h", i, if_pc, if_instr, e); else passed++;
            total++; if (npc !== e + 30'h1) $display("FAIL seq_npc%0d got=%h exp=%h", i, npc, e + 30'h1); else passed++;
            next_cycle();
        end
    endtask

    task automatic test_ack_delay;
        next_cycle();
        next_cycle();
        set_in(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if ({pc_write, imem_req, if_valid} !== 3'b010) $display("FAIL wait_ctl%0d got=%b exp=010", i, {pc_write, imem_req, if_valid}); else passed++;
            total++; if (imem_addr !== 30'h0000C05 || npc !== 30'h0000C05) $display("FAIL wait_addr%0d got=%h/%h exp=c05/c05", i, imem_addr, npc); else passed++;
            next_cycle();
        end
        imem_ack = 1'b1;
        @(negedge clk);
        total++; if ({pc_write, if_valid} !== 2'b11 || if_pc !== 30'h0000C05) $display("FAIL ack_late got=%b/%h exp=11/c05", {pc_write, if_valid}, if_pc); else passed++;
        total++; if (npc !== 30'h0000C06) $display("FAIL ack_late_npc got=%h exp=c06", npc); else passed++;
        next_cycle();
    endtask

    task automatic test_redirect_drain;
        next_cycle();
        next_cycle();
        set_in(1'b0, 1'b0, 1'b1, 30'h0000D00, 1'b0, 1'b0, 30'h0);
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b010) $display("FAIL br_pend got=%b exp=010", {pc_write, imem_req, if_valid}); else passed++;
        next_cycle();
        set_in(1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 1'b0, 30'h0);
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b010 || imem_addr !== 30'h0000C08) $display("FAIL drain_exc got=%b/%h exp=010/c08", {pc_write, imem_req, if_valid}, imem_addr); else passed++;
        next_cycle();
        set_in(1'b0, 1'b0, 1'b1, 30'h0000D00, 1'b0, 1'b0, 30'h0);
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b010) $display("FAIL drain_br got=%b exp=010", {pc_write, imem_req, if_valid}); else passed++;
        next_cycle();
        set_in(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0);
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b110) $display("FAIL drain_ack got=%b exp=110", {pc_write, imem_req, if_valid}); else passed++;
        total++; if (npc !== 30'h0001060) $display("FAIL drain_npc got=%h exp=1060", npc); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (if_valid !== 1'b1 || if_pc !== 30'h0001060 || npc !== 30'h0001061) $display("FAIL exc_fetch got=%b/%h/%h exp=1/1060/1061", if_valid, if_pc, npc); else passed++;
        next_cycle();
    endtask

    task automatic test_stall_hold;
        set_in(1'b1, 1'b0, 1'b1, 30'h0000C10, 1'b0, 1'b0, 30'h0);
        @(negedge clk);
        total++; if ({pc_write, if_valid} !== 2'b10 || npc !== 30'h0000C10) $display("FAIL br_ack got=%b/%h exp=10/c10", {pc_write, if_valid}, npc); else passed++;
        next_cycle();
        set_in(1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0);
        @(negedge clk);
        total++; if (pc_write !== 1'b1 || npc !== 30'h0000C11) $display("FAIL stall_ack got=%b/%h exp=1/c11", pc_write, npc); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b001 || if_pc !== 30'h0000C10) $display("FAIL hold1 got=%b/%h exp=001/c10", {pc_write, imem_req, if_valid}, if_pc); else passed++;
        total++; if (if_instr !== {2'b10, 30'h0000C10} || npc !== 30'h0000C11) $display("FAIL hold1_data got=%h/%h exp=80000c10/c11", if_instr, npc); else passed++;
        next_cycle();
        stall = 1'b0;
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b001 || if_pc !== 30'h0000C10) $display("FAIL hold_xfer got=%b/%h exp=001/c10", {pc_write, imem_req, if_valid}, if_pc); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b111 || if_pc !== 30'h0000C11) $display("FAIL after_hold got=%b/%h exp=111/c11", {pc_write, imem_req, if_valid}, if_pc); else passed++;
        next_cycle();
    endtask

    task automatic test_hold_eret;
        set_in(1'b1, 1'b0, 1'b1, 30'h0000C10, 1'b0, 1'b0, 30'h0);
        next_cycle();
        set_in(1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0);
        next_cycle();
        set_in(1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 1'b1, 30'h0000C40);
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b100) $display("FAIL hold_eret got=%b exp=100", {pc_write, imem_req, if_valid}); else passed++;
        total++; if (npc !== 30'h0000C40) $display("FAIL hold_eret_npc got=%h exp=c40", npc); else passed++;
        next_cycle();
        set_in(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0);
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b111 || if_pc !== 30'h0000C40) $display("FAIL eret_fetch got=%b/%h exp=111/c40", {pc_write, imem_req, if_valid}, if_pc); else passed++;
        next_cycle();
    endtask

    task automatic test_wrap;
        set_in(1'b1, 1'b0, 1'b1, 30'h3FFFFFFF, 1'b0, 1'b0, 30'h0);
        next_cycle();
        br_taken = 1'b0;
        @(negedge clk);
        total++; if (if_pc !== 30'h3FFFFFFF || npc !== 30'h0 || pc_write !== 1'b1) $display("FAIL wrap got=%h/%h/%b exp=3fffffff/0/1", if_pc, npc, pc_write); else passed++;
        next_cycle();
    endtask

    task automatic test_reset_drain;
        set_in(1'b0, 1'b0, 1'b1, 30'h0000555, 1'b0, 1'b0, 30'h0);
        next_cycle();
        br_taken = 1'b0;
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b010) $display("FAIL pre_rst_drain got=%b exp=010", {pc_write, imem_req, if_valid}); else passed++;
        #1 reset = 1'b0;
        #1;
        total++; if ({pc_write, imem_req, if_valid} !== 3'b000 || npc !== 30'h0000C00) $display("FAIL rst_drain got=%b/%h exp=000/c00", {pc_write, imem_req, if_valid}, npc); else passed++;
        next_cycle();
        reset = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        total++; if ({pc_write, imem_req, if_valid} !== 3'b000) $display("FAIL rst_idle got=%b exp=000", {pc_write, imem_req, if_valid}); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (if_pc !== 30'h0000C00 || npc !== 30'h0000C01) $display("FAIL rst_refetch got=%h/%h exp=c00/c01", if_pc, npc); else passed++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_ack_delay();
        test_redirect_drain();
        test_stall_hold();
        test_hold_eret();
        test_wrap();
        test_reset_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
